memwb_reg: RTL and testbench
============================

MEMWB_REG -- requirements
Module: memwb_reg

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low, with ports named cpu_clk_50M and cpu_rst_n.
REQ-003 cpu_clk_50M  in  1  pipeline clock; all state updates on the rising edge.
REQ-004 cpu_rst_n  in  1  asynchronous active-low reset.
REQ-005 mem_wa  in  5  destination GPR address from the memory stage.
REQ-006 mem_wreg  in  1  GPR write enable.
REQ-007 mem_whilo  in  1  HI/LO write enable.
REQ-008 mem_mreg  in  1  result comes from data memory (load).
REQ-009 mem_dreg  in  32  ALU result or effective address.
REQ-010 mem_dhilo  in  64  HI/LO write data.
REQ-011 mem_dre  in  4  byte-lane read enables of the access.
REQ-012 mem_dce  in  1  data memory access enable.
REQ-013 dm_dout  in  32  synchronous data memory read data, valid only in the cycle after the access.
REQ-014 stall  in  1  hold request for this register.
REQ-015 flush  in  1  squash request.
REQ-016 wb_wa, wb_wreg, wb_whilo, wb_mreg, wb_dreg, wb_dhilo, wb_dre  out  5/1/1/1/32/64/4  registered copies of the corresponding mem_* inputs.
REQ-017 wb_dm  out  32  load data, stable for as long as the load stays in writeback.
REQ-018 wb_ld_state  out  2  load-capture state (00 EMPTY, 01 FRESH, 10 HELD) for debug and coverage.

Function
REQ-019 On a rising edge with flush=1, all wb_* pipeline registers SHALL load zero and the state SHALL go to EMPTY, whatever the value of stall.
REQ-020 On a rising edge with flush=0 and stall=1, all wb_* pipeline registers SHALL hold their values.
REQ-021 On a rising edge with flush=0 and stall=0, all wb_* pipeline registers SHALL load the mem_* inputs, giving a latency of 1 cycle.
REQ-022 With flush=0 and stall=0, the state SHALL go to FRESH if mem_mreg=1 and mem_dce=1, else to EMPTY.
REQ-023 With flush=0 and stall=1: FRESH SHALL go to HELD, HELD SHALL stay HELD, and EMPTY SHALL stay EMPTY.
REQ-024 In FRESH, wb_dm SHALL equal dm_dout combinationally, and the 32-bit hold register SHALL capture dm_dout at the next edge.
REQ-025 In HELD, wb_dm SHALL equal the hold register; later changes on dm_dout SHALL NOT affect it.
REQ-026 In EMPTY, wb_dm SHALL be 32'h0.
REQ-027 The hold register SHALL capture only when leaving FRESH; it SHALL hold in all other cases.
REQ-028 A load followed back-to-back by a load, with no stall, SHALL go FRESH to FRESH, and each load SHALL see its own dm_dout.
REQ-029 Reset asserted mid-operation, including in HELD, SHALL immediately zero all outputs; no data SHALL survive reset.
REQ-030 Byte selection and sign extension are done downstream; wb_dm SHALL be the raw 32-bit word, and wb_dre SHALL be passed alongside it for that purpose.

Reset
REQ-031 While cpu_rst_n=0: all wb_* outputs, including wb_dm, SHALL be 0, the hold register SHALL be 0, and the state SHALL be EMPTY.
REQ-032 The first edge after reset release SHALL behave per REQ-019 to REQ-023.

Verification
REQ-033 Plain ALU op: mem_wa=5'd3, mem_wreg=1, mem_dreg=32'h1234_5678, stall=0 -> after one edge, wb_wa=3, wb_wreg=1, wb_dreg=32'h1234_5678, wb_dm=0, state EMPTY.
REQ-034 Load without stall: mem_mreg=1, mem_dce=1, mem_dre=4'hF, then next cycle dm_dout=32'hDEAD_BEEF -> wb_dm=32'hDEAD_BEEF in that cycle, state FRESH.
REQ-035 Load then stall for 3 cycles: dm_dout=32'hCAFE_0001 in the FRESH cycle, then 32'h0BAD_0BAD -> wb_dm stays 32'hCAFE_0001 throughout HELD; wb_* hold; the state returns to EMPTY or FRESH on the first unstalled edge.
REQ-036 Flush and stall together while in HELD -> next edge zeroes all wb_*, the state goes to EMPTY, and wb_dm=0.
REQ-037 Reset pulse in HELD with wb_dm=32'h5555_AAAA -> all outputs read 0 asynchronously before the next clock edge, and the state is EMPTY after release.
REQ-038 Back-to-back loads with dm_dout=32'h1111_1111 then 32'h2222_2222 and no stall -> wb_dm shows 32'h1111_1111 then 32'h2222_2222 on consecutive cycles, and the state is FRESH both cycles.

Source files
------------

// File: rtl/memwb_reg.sv
// memwb_reg: MEM/WB pipeline register with synchronous-read load data capture
// Ports: cpu_clk_50M/cpu_rst_n clock and async active-low reset;
//        mem_* memory-stage controls and data; dm_dout data memory read word;
//        stall holds the register, flush squashes it;
//        wb_* registered copies of mem_*; wb_dm raw load word held while the
//        load sits in writeback; wb_ld_state load-capture state for debug.
module memwb_reg (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic [4:0]  mem_wa,
    input  logic        mem_wreg,
    input  logic        mem_whilo,
    input  logic        mem_mreg,
    input  logic [31:0] mem_dreg,
    input  logic [63:0] mem_dhilo,
    input  logic [3:0]  mem_dre,
    input  logic        mem_dce,
    input  logic [31:0] dm_dout,
    input  logic        stall,
    input  logic        flush,
    output logic [4:0]  wb_wa,
    output logic        wb_wreg,
    output logic        wb_whilo,
    output logic        wb_mreg,
    output logic [31:0] wb_dreg,
    output logic [63:0] wb_dhilo,
    output logic [3:0]  wb_dre,
    output logic [31:0] wb_dm,
    output logic [1:0]  wb_ld_state
);
    typedef enum logic [1:0] {EMPTY = 2'b00, FRESH = 2'b01, HELD = 2'b10} ld_state_t;
    ld_state_t   state, state_nxt;
    logic [31:0] hold_q;
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n || flush) begin
            wb_wa    <= '0;
            wb_wreg  <= 1'b0;
            wb_whilo <= 1'b0;
            wb_mreg  <= 1'b0;
            wb_dreg  <= '0;
            wb_dhilo <= '0;
            wb_dre   <= '0;
        end else if (!stall) begin
            wb_wa    <= mem_wa;
            wb_wreg  <= mem_wreg;
            wb_whilo <= mem_whilo;
            wb_mreg  <= mem_mreg;
            wb_dreg  <= mem_dreg;
            wb_dhilo <= mem_dhilo;
            wb_dre   <= mem_dre;
        end
    end
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = EMPTY;
        else if (!stall)
            state_nxt = (mem_mreg && mem_dce) ? FRESH : EMPTY;
        else if (state == FRESH)
            state_nxt = HELD;
    end
    // read data is only valid in the FRESH cycle, so it is latched on the way out
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state  <= EMPTY;
            hold_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == FRESH && state_nxt != FRESH)
                hold_q <= dm_dout;
        end
    end
    assign wb_dm       = (state == FRESH) ? dm_dout : (state == HELD) ? hold_q : 32'h0;
    assign wb_ld_state = state;
endmodule

// File: tb/tb_memwb_reg.sv
// tb_memwb_reg: directed self-checking bench for memwb_reg
module tb_memwb_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  mem_wa = '0;
    logic        mem_wreg = 1'b0, mem_whilo = 1'b0, mem_mreg = 1'b0, mem_dce = 1'b0;
    logic [31:0] mem_dreg = '0, dm_dout = '0;
    logic [63:0] mem_dhilo = '0;
    logic [3:0]  mem_dre = '0;
    logic        stall = 1'b0, flush = 1'b0;
    logic [4:0]  wb_wa;
    logic        wb_wreg, wb_whilo, wb_mreg;
    logic [31:0] wb_dreg, wb_dm;
    logic [63:0] wb_dhilo;
    logic [3:0]  wb_dre;
    logic [1:0]  wb_ld_state;
    int checks = 0, errors = 0;
    bit run = 1'b0;

    memwb_reg dut (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
        .mem_wa(mem_wa), .mem_wreg(mem_wreg), .mem_whilo(mem_whilo), .mem_mreg(mem_mreg),
        .mem_dreg(mem_dreg), .mem_dhilo(mem_dhilo), .mem_dre(mem_dre), .mem_dce(mem_dce),
        .dm_dout(dm_dout), .stall(stall), .flush(flush),
        .wb_wa(wb_wa), .wb_wreg(wb_wreg), .wb_whilo(wb_whilo), .wb_mreg(wb_mreg),
        .wb_dreg(wb_dreg), .wb_dhilo(wb_dhilo), .wb_dre(wb_dre), .wb_dm(wb_dm),
        .wb_ld_state(wb_ld_state)
    );

    always #5 clk = ~clk;

    // model: the writeback slot either holds a load or not; a load is fresh in
    // its first cycle (data straight from memory) and afterwards uses the word
    // it saw in that first cycle
    logic [108:0] m_regs = '0;
    bit           m_load = 1'b0, m_fresh = 1'b0;
    logic [31:0]  m_cap = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_regs = '0; m_load = 1'b0; m_fresh = 1'b0; m_cap = '0;
        end else if (flush) begin
            m_regs = '0; m_load = 1'b0; m_fresh = 1'b0;
        end else if (stall) begin
            if (m_load && m_fresh) begin
                m_cap = dm_dout; m_fresh = 1'b0;
            end
        end else begin
            m_regs = {mem_wa, mem_wreg, mem_whilo, mem_mreg, mem_dreg, mem_dhilo, mem_dre};
            m_load = mem_mreg && mem_dce;
            m_fresh = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (run) begin
        chk("regs", {wb_wa, wb_wreg, wb_whilo, wb_mreg, wb_dreg, wb_dhilo, wb_dre}, m_regs);
        chk("dm", wb_dm, !m_load ? 32'h0 : m_fresh ? dm_dout : m_cap);
        chk("state", wb_ld_state, !m_load ? 2'd0 : m_fresh ? 2'd1 : 2'd2);
    end

    task automatic set_in(input [4:0] wa, input wreg, input whilo, input mreg,
                          input [31:0] dreg, input [63:0] dhilo, input [3:0] dre,
                          input dce, input st, input fl);
        mem_wa = wa; mem_wreg = wreg; mem_whilo = whilo; mem_mreg = mreg;
        mem_dreg = dreg; mem_dhilo = dhilo; mem_dre = dre; mem_dce = dce;
        stall = st; flush = fl;
    endtask

    // one edge; dm_dout is the word memory returns in the cycle after that edge
    task automatic step(input [31:0] d);
        @(posedge clk);
        #1 dm_dout = d;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dm", wb_dm, 32'h0);
        chk("rst_state", wb_ld_state, 2'd0);
        chk("rst_dhilo", wb_dhilo, 64'h0);
        run = 1'b1;
        rst_n = 1'b1;
        // plain ALU op
        set_in(5'd3, 1, 1, 0, 32'h1234_5678, 64'hAAAA_0000_BBBB_1111, 4'h0, 0, 0, 0);
        step(32'h7777_7777);
        chk("alu_wa", wb_wa, 5'd3);
        chk("alu_dreg", wb_dreg, 32'h1234_5678);
        chk("alu_dm", wb_dm, 32'h0);
        chk("alu_state", wb_ld_state, 2'd0);
        // load without stall
        set_in(5'd5, 1, 0, 1, 32'h0000_0100, 64'h0, 4'hF, 1, 0, 0);
        step(32'hDEAD_BEEF);
        chk("ld_dm", wb_dm, 32'hDEAD_BEEF);
        chk("ld_state", wb_ld_state, 2'd1);
        chk("ld_dre", wb_dre, 4'hF);
        // load, then stall three cycles while memory output changes
        set_in(5'd6, 1, 0, 1, 32'h0000_0104, 64'h0, 4'h3, 1, 0, 0);
        step(32'hCAFE_0001);
        chk("ld2_dm", wb_dm, 32'hCAFE_0001);
        set_in(5'd31, 0, 1, 0, 32'hFFFF_FFFF, 64'h1, 4'h1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(32'h0BAD_0BAD);
            chk("held_dm", wb_dm, 32'hCAFE_0001);
            chk("held_state", wb_ld_state, 2'd2);
            chk("held_wa", wb_wa, 5'd6);
        end
        set_in(5'd7, 1, 0, 0, 32'h0000_0042, 64'h0, 4'h0, 0, 0, 0);
        step(32'h0BAD_0BAD);
        chk("unstall_state", wb_ld_state, 2'd0);
        chk("unstall_dm", wb_dm, 32'h0);
        // back-to-back loads
        set_in(5'd8, 1, 0, 1, 32'h0000_0200, 64'h0, 4'hF, 1, 0, 0);
        step(32'h1111_1111);
        chk("b2b1_dm", wb_dm, 32'h1111_1111);
        chk("b2b1_state", wb_ld_state, 2'd1);
        set_in(5'd9, 1, 0, 1, 32'h0000_0204, 64'h0, 4'hC, 1, 0, 0);
        step(32'h2222_2222);
        chk("b2b2_dm", wb_dm, 32'h2222_2222);
        chk("b2b2_state", wb_ld_state, 2'd1);
        // stall into HELD, then flush and stall together
        stall = 1'b1;
        step(32'h3333_3333);
        chk("pre_flush_dm", wb_dm, 32'h2222_2222);
        flush = 1'b1;
        step(32'h4444_4444);
        chk("flush_state", wb_ld_state, 2'd0);
        chk("flush_dm", wb_dm, 32'h0);
        chk("flush_wa", wb_wa, 5'd0);
        // reset pulse while HELD
        set_in(5'd10, 1, 1, 1, 32'h0000_0300, 64'h55, 4'hF, 1, 0, 0);
        step(32'h5555_AAAA);
        stall = 1'b1;
        step(32'h0);
        chk("pre_rst_dm", wb_dm, 32'h5555_AAAA);
        rst_n = 1'b0;
        #1;
        chk("async_dm", wb_dm, 32'h0);
        chk("async_state", wb_ld_state, 2'd0);
        chk("async_wa", wb_wa, 5'd0);
        chk("async_dhilo", wb_dhilo, 64'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        set_in(5'd12, 1, 0, 0, 32'h0000_0ABC, 64'h0, 4'h0, 0, 0, 0);
        step(32'h9999_9999);
        chk("post_rst_state", wb_ld_state, 2'd0);
        chk("post_rst_dreg", wb_dreg, 32'h0000_0ABC);
        step(32'h9999_9999);
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
